// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and FSM state type for the PC update stage
package pc_pkg;

  localparam int SRC_EXC  = 0;
  localparam int SRC_EPC  = 1;
  localparam int SRC_ALU  = 2;
  localparam int SRC_SHL2 = 3;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_00FF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_src_mux_n.sv
// rtl/pc_src_mux_n.sv - N-way next-PC source mux, out-of-range select falls back to the exception source
module pc_src_mux_n
  import pc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [NUM_SRC*WIDTH-1:0] i_src_bus,
  output logic [WIDTH-1:0]         o_out
);

  always_comb begin
    o_out = i_src_bus[SRC_EXC*WIDTH +: WIDTH];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_out = i_src_bus[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - PC register with branch qualification, misaligned-target trap FSM and EPC
module pc_update_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NUM_SRC    = 4,
  parameter int               SEL_W      = $clog2(NUM_SRC),
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF),
  parameter int               ALIGN_BITS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         pc_src,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     zero,
  input  logic                     branch_ne,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         epc_out,
  output logic [WIDTH-1:0]         next_pc,
  output logic                     trap,
  output logic                     busy
);

  // A mask keeps the check well-formed when ALIGN_BITS is 0 (mask becomes all zeros).
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [WIDTH-1:0] w_next_pc;
  logic             w_take;
  logic             w_misaligned;

  pc_state_t        r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_trap;
  logic             r_busy;

  pc_src_mux_n #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .i_sel     (pc_src),
    .i_src_bus (src_bus),
    .o_out     (w_next_pc)
  );

  assign w_take       = pc_write | (pc_write_cond & (zero ^ branch_ne));
  assign w_misaligned = |(w_next_pc & ALIGN_MASK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_epc   <= '0;
      r_trap  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_trap <= 1'b0;
          r_busy <= 1'b0;
          if (w_take) begin
            if (w_misaligned) begin
              r_epc   <= r_pc;
              r_trap  <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_TRAP;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        // Write requests are deliberately ignored while the vector is loaded.
        ST_TRAP: begin
          r_pc    <= EXC_VECTOR;
          r_trap  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign next_pc = w_next_pc;
  assign pc_out  = r_pc;
  assign epc_out = r_epc;
  assign trap    = r_trap;
  assign busy    = r_busy;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - scoreboard bench for pc_update_unit (default build plus NUM_SRC=3 / no-align build)
module tb_pc_update_unit;

  localparam logic [31:0] EXC = 32'h0000_00FF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        trap;
    logic        busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;

  logic [1:0]   pc_src = '0;
  logic [127:0] src_bus = '0;
  logic         pc_write = 1'b0;
  logic         pc_write_cond = 1'b0;
  logic         zero = 1'b0;
  logic         branch_ne = 1'b0;
  logic [31:0]  pc_out, epc_out, next_pc;
  logic         trap, busy;

  logic [1:0]   pc_src2 = '0;
  logic [95:0]  src_bus2 = '0;
  logic         pc_write2 = 1'b0;
  logic [31:0]  pc_out2, epc_out2, next_pc2;
  logic         trap2, busy2;

  int n_checks = 0;
  int n_fail = 0;

  exp_t        sb_q[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_epc = '0;
  logic        m_trap_st = 1'b0;

  always #5 clk = ~clk;

  pc_update_unit #(
    .WIDTH(32), .NUM_SRC(4), .RESET_PC(32'h0), .EXC_VECTOR(EXC), .ALIGN_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .src_bus(src_bus),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero(zero), .branch_ne(branch_ne),
    .pc_out(pc_out), .epc_out(epc_out), .next_pc(next_pc), .trap(trap), .busy(busy)
  );

  pc_update_unit #(
    .WIDTH(32), .NUM_SRC(3), .RESET_PC(32'h0), .EXC_VECTOR(EXC), .ALIGN_BITS(0)
  ) dut3 (
    .clk(clk), .reset(reset), .pc_src(pc_src2), .src_bus(src_bus2),
    .pc_write(pc_write2), .pc_write_cond(1'b0), .zero(1'b0), .branch_ne(1'b0),
    .pc_out(pc_out2), .epc_out(epc_out2), .next_pc(next_pc2), .trap(trap2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [31:0] val);
    src_bus[idx*32 +: 32] = val;
  endtask

  // Drive one cycle of requests, predict the post-edge state, then compare after the edge.
  task automatic step(input string tag, input logic [1:0] sel, input logic pw,
                      input logic pwc, input logic z, input logic bne);
    logic [31:0] sel_val;
    logic        take;
    exp_t        e, got;
    pc_src = sel; pc_write = pw; pc_write_cond = pwc; zero = z; branch_ne = bne;
    #1;
    sel_val = src_bus[32*sel +: 32];
    check({tag, "_next_pc"}, next_pc, sel_val);
    take = pw | (pwc & (z ^ bne));
    e.trap = 1'b0;
    e.busy = 1'b0;
    if (m_trap_st) begin
      m_pc = EXC;
      m_trap_st = 1'b0;
    end else if (take) begin
      if (sel_val[1:0] != 2'b00) begin
        m_epc = m_pc;
        e.trap = 1'b1;
        e.busy = 1'b1;
        m_trap_st = 1'b1;
      end else begin
        m_pc = sel_val;
      end
    end
    e.pc = m_pc;
    e.epc = m_epc;
    sb_q.push_back(e);
    tick();
    pc_write = 1'b0; pc_write_cond = 1'b0;
    e = sb_q.pop_front();
    got = '{pc: pc_out, epc: epc_out, trap: trap, busy: busy};
    check({tag, "_pc"}, got.pc, e.pc);
    check({tag, "_epc"}, got.epc, e.epc);
    check({tag, "_trap"}, {31'b0, got.trap}, {31'b0, e.trap});
    check({tag, "_busy"}, {31'b0, got.busy}, {31'b0, e.busy});
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check("rst_pc", pc_out, 32'h0);
    check("rst_epc", epc_out, 32'h0);
    check("rst_trap", {31'b0, trap}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    tick();
    reset = 1'b0;

    set_src(0, 32'd4); set_src(1, 32'd8); set_src(2, 32'd12); set_src(3, 32'd16);
    for (int i = 0; i < 4; i++) begin
      step("sweep", 2'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      check("sweep_const", pc_out, 32'd4 * (i + 1));
    end

    set_src(2, 32'h40);
    step("beq_taken", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    check("beq_const", pc_out, 32'h40);
    set_src(2, 32'h80);
    step("bne_hold", 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    check("bne_hold_const", pc_out, 32'h40);
    step("bne_taken", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    set_src(2, 32'hC0);
    step("beq_hold", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    set_src(2, 32'h100);
    step("both_or", 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    step("idle", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    set_src(2, 32'h102);
    step("trap", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("trap_epc_const", epc_out, 32'h100);
    check("trap_pc_const", pc_out, 32'h100);
    set_src(2, 32'h200);
    step("in_trap", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("vector_const", pc_out, EXC);
    step("after_trap", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("after_trap_const", pc_out, 32'h200);

    set_src(2, 32'h202);
    step("trap2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_pc", pc_out, 32'h0);
    check("mid_rst_epc", epc_out, 32'h0);
    check("mid_rst_trap", {31'b0, trap}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    #1 reset = 1'b0;
    m_pc = '0; m_epc = '0; m_trap_st = 1'b0;
    step("post_rst_hold", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    set_src(1, 32'h10);
    step("post_rst_write", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    src_bus2 = {32'h30, 32'h20, 32'h102};
    pc_src2 = 2'd3;
    #1;
    check("n3_oor_next", next_pc2, 32'h102);
    pc_write2 = 1'b1;
    tick();
    pc_write2 = 1'b0;
    check("n3_pc", pc_out2, 32'h102);
    check("n3_trap", {31'b0, trap2}, 32'h0);
    check("n3_busy", {31'b0, busy2}, 32'h0);
    check("n3_epc", epc_out2, 32'h0);
    pc_src2 = 2'd1;
    #1;
    check("n3_sel1_next", next_pc2, 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
